regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with an in-flight write scoreboard. It is the next-generation replacement for the single-write, two-read core register file. It sits between decode and writeback: decode reads operands and marks destination registers pending, and one or more writeback ports retire results and clear the pending marks. Register 0 is hardwired to zero, and all state resets asynchronously.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2)
- NREAD, 2, number of read ports
- NWRITE, 2, number of write ports; a higher index has higher priority
- AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NREAD×AW  read addresses
- rd_data  out  NREAD×XLEN  read data (combinational)
- rd_busy  out  NREAD  addressed register has a write in flight
- wr_en  in  NWRITE  write strobes
- wr_addr  in  NWRITE×AW  write addresses
- wr_data  in  NWRITE×XLEN  write data
- issue_en  in  1  mark issue_addr pending
- issue_addr  in  AW  destination register of the newly issued instruction
- pending  out  NREGS  scoreboard vector; bit 0 is always 0

## Operation
- Storage is NREGS×XLEN flops. Reading register 0 returns 0. Writes and issues to register 0 are ignored.
- Write: on a clock edge with wr_en[k]=1 and wr_addr[k]≠0, the register loads wr_data[k].
- Several ports writing the same address in one cycle: the highest-index port wins. Ports writing different addresses all commit.
- Scoreboard bit p[i] behaviour on a clock edge:
  - Cleared by any enabled write to i.
  - Set by issue_en with issue_addr=i.
  - Issue and write to the same i in the same cycle: the bit ends set, because the new producer supersedes the retiring one.
  - Otherwise the bit holds.
- Issue to a register that is already pending: the bit stays set. There is no counting; the pipeline guarantees at most one outstanding producer per register.
- rd_busy[j] = p[rd_addr[j]], subject to the bypass rule in Configuration. rd_busy is always 0 for address 0.
- Reset (reset_n=0, asynchronous, at any time including mid-write): all registers are 0 and pending is all-zero. Writes and issues are ignored while reset is asserted. Normal operation resumes on the first rising clock edge after deassertion.

## Timing
- Read is zero-latency combinational from rd_addr and register state.
- Write is visible on rd_data the cycle after the write edge (without bypass).
- Scoreboard set/clear is visible on pending and rd_busy the cycle after the edge.
- Outputs during and after reset: rd_data=0, rd_busy=0, pending=0.
- There is no handshake or backpressure. The block accepts every write and issue every cycle.

## Configuration
- Macro REGFILE_MP_BYPASS_EN.
- When defined:
  - rd_data[j] returns the winning same-cycle wr_data when an enabled write targets rd_addr[j]≠0.
  - rd_busy[j] is forced to 0 for that address. Same-cycle issue_en is not considered.
- When undefined: rd_data and rd_busy reflect registered state only, so a write is seen one cycle late.

## Structure
- Shared package regfile_pkg holds:
  - Default constants XLEN_DEF and NREGS_DEF.
  - Typedefs reg_addr_t and reg_data_t.
  - The function wr_select, which returns the winning write port index and a hit flag for a given address.
- One natural sub-module: regfile_scoreboard, containing the pending vector and its set/clear/reset logic, instantiated once. The data array and read muxing remain in regfile_mp.

## Test plan
- Reset: assert reset_n=0 mid-run after writing reg 5 = 0xDEADBEEF → rd_data for reg 5 = 0 and pending = 0 immediately, without a clock edge.
- Conflict: wr0 (reg 3, 0x11) and wr1 (reg 3, 0x22) in the same cycle → next cycle reg 3 reads 0x22. Separately, wr0 (reg 3) and wr1 (reg 4) → both commit.
- Register 0: write 0xFFFFFFFF to reg 0 and issue reg 0 → reg 0 reads 0, pending[0]=0, rd_busy=0.
- Scoreboard: issue reg 7 → pending[7]=1 next cycle. Then issue reg 7 and write reg 7 in the same cycle → pending[7] stays 1. Then write alone → pending[7]=0.
- Bypass (REGFILE_MP_BYPASS_EN defined): with pending[9]=1, write reg 9 = 0x1234 while reading reg 9 → same cycle rd_data=0x1234 and rd_busy=0. With the macro undefined → old value and rd_busy=1.
- Parameters: NREAD=3, NWRITE=1, NREGS=16, XLEN=64 → all read ports return correct 64-bit data for random write sequences checked against a model.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and write-port arbitration for regfile_mp
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Upper bounds for the arbitration helper; instances zero-pad their ports up to these.
    localparam int WR_MAX   = 8;
    localparam int AW_MAX   = 16;
    localparam int WR_IDX_W = $clog2(WR_MAX);

    typedef logic [XLEN_DEF-1:0]          reg_data_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

    typedef struct packed {
        logic                hit;
        logic [WR_IDX_W-1:0] idx;
    } wr_sel_t;

    // Highest-index enabled port whose address matches target wins.
    function automatic wr_sel_t wr_select(
        input logic [WR_MAX-1:0]        en,
        input logic [WR_MAX*AW_MAX-1:0] addr,
        input logic [AW_MAX-1:0]        target,
        input int                       nwrite,
        input int                       aw
    );
        wr_sel_t sel;
        logic    match;
        sel = '0;
        for (int k = 0; k < WR_MAX; k++) begin
            match = 1'b1;
            for (int b = 0; b < AW_MAX; b++) begin
                if (b < aw && addr[k*aw+b] != target[b]) begin
                    match = 1'b0;
                end
            end
            if (k < nwrite && en[k] && match) begin
                sel.hit = 1'b1;
                sel.idx = WR_IDX_W'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - in-flight write scoreboard: issue sets, writeback clears, register 0 never pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NWRITE-1:0] wr_en,
    input  logic [NWRITE*AW-1:0] wr_addr,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] clr;
    logic [NREGS-1:0] set;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        clr = '0;
        set = '0;
        for (int k = 0; k < NWRITE; k++) begin
            if (wr_en[k]) begin
                clr[wr_addr[k*AW +: AW]] = 1'b1;
            end
        end
        if (issue_en) begin
            set[issue_addr] = 1'b1;
        end
        pending_d    = (pending_q & ~clr) | set;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write scoreboard; REGFILE_MP_BYPASS_EN enables write-to-read bypass
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NREAD*AW-1:0]    rd_addr,
    output logic [NREAD*XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]       rd_busy,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_addr,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_addr,
    output logic [NREGS-1:0]       pending
);

    logic [XLEN-1:0]          regs_q [NREGS];
    logic [XLEN-1:0]          regs_d [NREGS];
    logic [WR_MAX-1:0]        en_pad;
    logic [WR_MAX*AW_MAX-1:0] addr_pad;

    assign en_pad   = WR_MAX'(wr_en);
    assign addr_pad = (WR_MAX*AW_MAX)'(wr_addr);

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE),
        .AW     (AW)
    ) u_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pending    (pending)
    );

    always_comb begin
        wr_sel_t sel;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            sel = wr_select(en_pad, addr_pad, AW_MAX'(i), NWRITE, AW);
            if (i != 0 && sel.hit) begin
                regs_d[i] = wr_data[int'(sel.idx)*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
`ifdef REGFILE_MP_BYPASS_EN
        wr_sel_t       bsel;
`endif
        rd_data = '0;
        rd_busy = '0;
        for (int j = 0; j < NREAD; j++) begin
            ra = rd_addr[j*AW +: AW];
            rd_data[j*XLEN +: XLEN] = (ra == '0) ? '0 : regs_q[ra];
            rd_busy[j]              = pending[ra];
`ifdef REGFILE_MP_BYPASS_EN
            // Gated by reset so outputs stay zero while reset is held.
            bsel = wr_select(en_pad, addr_pad, AW_MAX'(ra), NWRITE, AW);
            if (reset_n && ra != '0 && bsel.hit) begin
                rd_data[j*XLEN +: XLEN] = wr_data[int'(bsel.idx)*XLEN +: XLEN];
                rd_busy[j]              = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp (default and 3R/1W/16x64 instances)
module tb_regfile_mp;

    logic         clock;
    logic         reset_n;

    logic [9:0]   rd_addr;
    logic [63:0]  rd_data;
    logic [1:0]   rd_busy;
    logic [1:0]   wr_en;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         issue_en;
    logic [4:0]   issue_addr;
    logic [31:0]  pending;

    logic [11:0]  rd_addr2;
    logic [191:0] rd_data2;
    logic [2:0]   rd_busy2;
    logic [0:0]   wr_en2;
    logic [3:0]   wr_addr2;
    logic [63:0]  wr_data2;
    logic         issue_en2;
    logic [3:0]   issue_addr2;
    logic [15:0]  pending2;

    logic [31:0]  rd0;
    logic [31:0]  rd1;
    logic [63:0]  model2 [16];

    int checks = 0;
    int errors = 0;

    assign rd0 = rd_data[31:0];
    assign rd1 = rd_data[63:32];

    regfile_mp dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .pending    (pending)
    );

    regfile_mp #(
        .XLEN   (64),
        .NREGS  (16),
        .NREAD  (3),
        .NWRITE (1)
    ) dut2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr2),
        .rd_data    (rd_data2),
        .rd_busy    (rd_busy2),
        .wr_en      (wr_en2),
        .wr_addr    (wr_addr2),
        .wr_data    (wr_data2),
        .issue_en   (issue_en2),
        .issue_addr (issue_addr2),
        .pending    (pending2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
        wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0;
        issue_en2 = 1'b0; issue_addr2 = '0;
    endtask

    task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
        wr_en[k] = 1'b1;
        wr_addr[k*5 +: 5] = a;
        wr_data[k*32 +: 32] = d;
    endtask

    task automatic test_reset();
        idle();
        rd_addr = {5'd0, 5'd5};
        rd_addr2 = '0;
        #1;
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", rd0, 32'h0); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h expected %h", pending, 32'h0); end
        repeat (2) tick();
        reset_n = 1'b1;
        wr(0, 5'd5, 32'hDEADBEEF);
        issue_en = 1'b1; issue_addr = 5'd6;
        tick();
        idle();
        #1;
        checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_write: got %h expected %h", rd0, 32'hDEADBEEF); end
        checks++; if (pending !== 32'h40) begin errors++; $display("FAIL pre_reset_pending: got %h expected %h", pending, 32'h40); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL async_reset_data: got %h expected %h", rd0, 32'h0); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL async_reset_pending: got %h expected %h", pending, 32'h0); end
        wr(0, 5'd5, 32'h55);
        issue_en = 1'b1; issue_addr = 5'd5;
        tick();
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL write_in_reset: got %h expected %h", rd0, 32'h0); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL issue_in_reset: got %h expected %h", pending, 32'h0); end
        idle();
        reset_n = 1'b1;
        tick();
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL post_reset_data: got %h expected %h", rd0, 32'h0); end
    endtask

    task automatic test_conflict();
        idle();
        wr(0, 5'd3, 32'h11);
        wr(1, 5'd3, 32'h22);
        tick();
        idle();
        rd_addr = {5'd4, 5'd3};
        #1;
        checks++; if (rd0 !== 32'h22) begin errors++; $display("FAIL conflict_same_addr: got %h expected %h", rd0, 32'h22); end
        wr(0, 5'd3, 32'h33);
        wr(1, 5'd4, 32'h44);
        tick();
        idle();
        #1;
        checks++; if (rd0 !== 32'h33) begin errors++; $display("FAIL split_port0: got %h expected %h", rd0, 32'h33); end
        checks++; if (rd1 !== 32'h44) begin errors++; $display("FAIL split_port1: got %h expected %h", rd1, 32'h44); end
        wr(0, 5'd3, 32'h55);
        wr_addr[9:5] = 5'd3; wr_data[63:32] = 32'h66;
        tick();
        idle();
        #1;
        checks++; if (rd0 !== 32'h55) begin errors++; $display("FAIL disabled_port1: got %h expected %h", rd0, 32'h55); end
        checks++; if (rd1 !== 32'h44) begin errors++; $display("FAIL untouched_reg4: got %h expected %h", rd1, 32'h44); end
    endtask

    task automatic test_reg0();
        idle();
        rd_addr = {5'd0, 5'd0};
        wr(1, 5'd0, 32'hFFFFFFFF);
        issue_en = 1'b1; issue_addr = 5'd0;
        #1;
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reg0_same_cycle: got %h expected %h", rd0, 32'h0); end
        tick();
        idle();
        #1;
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reg0_data: got %h expected %h", rd0, 32'h0); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL reg0_pending: got %h expected %h", pending, 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL reg0_busy: got %b expected %b", rd_busy, 2'b00); end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {5'd8, 5'd7};
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        #1;
        checks++; if (pending !== 32'h80) begin errors++; $display("FAIL issue_sets: got %h expected %h", pending, 32'h80); end
        checks++; if (rd_busy !== 2'b01) begin errors++; $display("FAIL busy_ports: got %b expected %b", rd_busy, 2'b01); end
        issue_en = 1'b1; issue_addr = 5'd7;
        tick();
        idle();
        checks++; if (pending !== 32'h80) begin errors++; $display("FAIL reissue_holds: got %h expected %h", pending, 32'h80); end
        issue_en = 1'b1; issue_addr = 5'd7;
        wr(1, 5'd7, 32'h77);
        tick();
        idle();
        #1;
        checks++; if (pending !== 32'h80) begin errors++; $display("FAIL issue_beats_write: got %h expected %h", pending, 32'h80); end
        checks++; if (rd0 !== 32'h77) begin errors++; $display("FAIL retire_data: got %h expected %h", rd0, 32'h77); end
        wr(0, 5'd7, 32'h78);
        tick();
        idle();
        #1;
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL write_clears: got %h expected %h", pending, 32'h0); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL busy_cleared: got %b expected %b", rd_busy, 2'b00); end
    endtask

    task automatic test_bypass();
        idle();
        wr(0, 5'd9, 32'hAAAA);
        tick();
        idle();
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        idle();
        rd_addr = {5'd9, 5'd9};
        wr(0, 5'd9, 32'h9999);
        wr(1, 5'd9, 32'h1234);
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        checks++; if (rd0 !== 32'h1234) begin errors++; $display("FAIL bypass_data: got %h expected %h", rd0, 32'h1234); end
        checks++; if (rd_busy !== 2'b00) begin errors++; $display("FAIL bypass_busy: got %b expected %b", rd_busy, 2'b00); end
`else
        checks++; if (rd0 !== 32'hAAAA) begin errors++; $display("FAIL nobypass_data: got %h expected %h", rd0, 32'hAAAA); end
        checks++; if (rd_busy !== 2'b11) begin errors++; $display("FAIL nobypass_busy: got %b expected %b", rd_busy, 2'b11); end
`endif
        tick();
        idle();
        #1;
        checks++; if (rd1 !== 32'h1234) begin errors++; $display("FAIL after_write_data: got %h expected %h", rd1, 32'h1234); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL after_write_pending: got %h expected %h", pending, 32'h0); end
    endtask

    task automatic test_params();
        logic [3:0]  a;
        logic [63:0] d;
        idle();
        for (int i = 0; i < 16; i++) model2[i] = '0;
        for (int n = 0; n < 40; n++) begin
            a = 4'($urandom_range(0, 15));
            d = {$urandom, $urandom};
            wr_en2 = 1'($urandom_range(0, 3) != 0);
            wr_addr2 = a;
            wr_data2 = d;
            tick();
            if (wr_en2[0] && a != 4'd0) model2[a] = d;
            wr_en2 = '0;
            rd_addr2 = 12'($urandom);
            #1;
            for (int j = 0; j < 3; j++) begin
                a = rd_addr2[j*4 +: 4];
                checks++;
                if (rd_data2[j*64 +: 64] !== model2[a]) begin
                    errors++;
                    $display("FAIL wide_read port %0d reg %0d: got %h expected %h", j, a, rd_data2[j*64 +: 64], model2[a]);
                end
            end
        end
        issue_en2 = 1'b1; issue_addr2 = 4'd15;
        tick();
        idle();
        rd_addr2 = {4'd0, 4'd15, 4'd1};
        #1;
        checks++; if (pending2 !== 16'h8000) begin errors++; $display("FAIL wide_pending: got %h expected %h", pending2, 16'h8000); end
        checks++; if (rd_busy2 !== 3'b010) begin errors++; $display("FAIL wide_busy: got %b expected %b", rd_busy2, 3'b010); end
    endtask

    initial begin
        reset_n = 1'b0;
        rd_addr = '0;
        rd_addr2 = '0;
        idle();
        test_reset();
        test_conflict();
        test_reg0();
        test_scoreboard();
        test_bypass();
        test_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
